// File: rtl/m68k_ram_bridge.sv
// Bridges raw 68000 bus cycles onto a byte-laned 16-bit work RAM with
// programmable wait states, a DTACK_n handshake and an external hold.
module m68k_ram_bridge #(
   parameter int WIDTHAD     = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               cs,
   input  logic               as_n,
   input  logic               uds_n,
   input  logic               lds_n,
   input  logic               rw,
   input  logic [WIDTHAD-1:0] addr,
   input  logic [15:0]        din,
   output logic [15:0]        dout,
   output logic               dtack_n,
   input  logic               ram_hold,
   output logic [WIDTHAD-1:0] ram_address,
   output logic [15:0]        ram_data,
   output logic               ram_we_uds_n,
   output logic               ram_we_lds_n,
   input  logic [15:0]        ram_q
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_ACK
   } state_t;

   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t     state;
   logic [3:0] wait_cnt;
   logic       is_read;
   logic       lane_u;
   logic       lane_l;
   logic       request;
   logic       write_now;

   assign request = cs && !as_n && (!uds_n || !lds_n);

   // Strobes are decoded from state so the RAM sees exactly one write clock,
   // and never while another agent owns it.
   assign write_now    = (state == ST_ACCESS) && !is_read && !ram_hold;
   assign ram_we_uds_n = !(write_now && lane_u);
   assign ram_we_lds_n = !(write_now && lane_l);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         wait_cnt    <= 4'd0;
         is_read     <= 1'b0;
         lane_u      <= 1'b0;
         lane_l      <= 1'b0;
         dout        <= 16'd0;
         dtack_n     <= 1'b1;
         ram_address <= '0;
         ram_data    <= 16'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (request) begin
                  ram_address <= addr;
                  ram_data    <= din;
                  is_read     <= rw;
                  lane_u      <= !uds_n;
                  lane_l      <= !lds_n;
                  wait_cnt    <= WAIT_LOAD;
                  if (WAIT_STATES > 0)
                     state <= ST_WAIT;
                  else
                     state <= ST_ACCESS;
               end
            end
            ST_WAIT: begin
               if (as_n)
                  state <= ST_IDLE;
               else if (wait_cnt == 4'd0)
                  state <= ST_ACCESS;
               else
                  wait_cnt <= wait_cnt - 4'd1;
            end
            // A held access may still be abandoned by the CPU.
            ST_ACCESS: begin
               if (ram_hold) begin
                  if (as_n)
                     state <= ST_IDLE;
               end else begin
                  if (is_read)
                     dout <= ram_q;
                  dtack_n <= 1'b0;
                  state   <= ST_ACK;
               end
            end
            ST_ACK: begin
               if (as_n) begin
                  dtack_n <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m68k_ram_bridge.sv
// Directed bench for m68k_ram_bridge: three instances (0, 1 and 4 wait states)
// share the bus stimulus and each test checks the instance it targets.
module tb_m68k_ram_bridge;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        cs, as_n, uds_n, lds_n, rw, ram_hold;
   logic [9:0]  addr;
   logic [15:0] din, ram_q;

   logic [15:0] u0_dout, u1_dout, u4_dout;
   logic        u0_dtack, u1_dtack, u4_dtack;
   logic [9:0]  u0_addr, u1_addr, u4_addr;
   logic [15:0] u0_data, u1_data, u4_data;
   logic        u0_we_u, u1_we_u, u4_we_u;
   logic        u0_we_l, u1_we_l, u4_we_l;

   int checks   = 0;
   int failures = 0;

   // Sticky monitors for windows where a single edge check is not enough.
   logic mon4 = 1'b0, seen4 = 1'b0;
   logic mon5 = 1'b0, seen5 = 1'b0;
   logic mon6 = 1'b0;
   int   pulses_u6 = 0, pulses_l6 = 0, acks6 = 0;

   always #5 clock = ~clock;

   m68k_ram_bridge #(.WIDTHAD(10), .WAIT_STATES(0)) dut0 (
      .clock(clock), .reset_n(reset_n), .cs(cs), .as_n(as_n), .uds_n(uds_n),
      .lds_n(lds_n), .rw(rw), .addr(addr), .din(din), .dout(u0_dout),
      .dtack_n(u0_dtack), .ram_hold(ram_hold), .ram_address(u0_addr),
      .ram_data(u0_data), .ram_we_uds_n(u0_we_u), .ram_we_lds_n(u0_we_l),
      .ram_q(ram_q));

   m68k_ram_bridge #(.WIDTHAD(10), .WAIT_STATES(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .cs(cs), .as_n(as_n), .uds_n(uds_n),
      .lds_n(lds_n), .rw(rw), .addr(addr), .din(din), .dout(u1_dout),
      .dtack_n(u1_dtack), .ram_hold(ram_hold), .ram_address(u1_addr),
      .ram_data(u1_data), .ram_we_uds_n(u1_we_u), .ram_we_lds_n(u1_we_l),
      .ram_q(ram_q));

   m68k_ram_bridge #(.WIDTHAD(10), .WAIT_STATES(4)) dut4 (
      .clock(clock), .reset_n(reset_n), .cs(cs), .as_n(as_n), .uds_n(uds_n),
      .lds_n(lds_n), .rw(rw), .addr(addr), .din(din), .dout(u4_dout),
      .dtack_n(u4_dtack), .ram_hold(ram_hold), .ram_address(u4_addr),
      .ram_data(u4_data), .ram_we_uds_n(u4_we_u), .ram_we_lds_n(u4_we_l),
      .ram_q(ram_q));

   always @(negedge clock) begin
      if (mon4 && (!u4_dtack || !u4_we_u || !u4_we_l))
         seen4 <= 1'b1;
      if (mon5 && (!u1_we_u || !u1_we_l || !u1_dtack))
         seen5 <= 1'b1;
      if (mon6) begin
         if (!u1_we_u) pulses_u6 <= pulses_u6 + 1;
         if (!u1_we_l) pulses_l6 <= pulses_l6 + 1;
         if (!u1_dtack) acks6 <= acks6 + 1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic a_as_n, input logic a_uds_n,
                                input logic a_lds_n, input logic a_rw,
                                input logic [9:0] a_addr, input logic [15:0] a_din);
      cs    = 1'b1;
      as_n  = a_as_n;
      uds_n = a_uds_n;
      lds_n = a_lds_n;
      rw    = a_rw;
      addr  = a_addr;
      din   = a_din;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      ram_hold = 1'b0;
      ram_q    = 16'h0000;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 10'h000, 16'h0000);
      cs = 1'b0;
      #12;
      reset_n = 1'b1;
      #1;
      checkOutput("reset_dtack", {31'd0, u1_dtack}, 32'd1);
      checkOutput("reset_dout", {16'd0, u1_dout}, 32'h0);
      checkOutput("reset_addr", {22'd0, u1_addr}, 32'h0);
      checkOutput("reset_data", {16'd0, u1_data}, 32'h0);
      checkOutput("reset_we", {30'd0, u1_we_u, u1_we_l}, 32'd3);
      tick();

      // Word write, one wait state.
      $display("[TB] word write");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'h123, 16'hBEEF);
      tick();
      checkOutput("ww_wait_we", {30'd0, u1_we_u, u1_we_l}, 32'd3);
      checkOutput("ww_addr", {22'd0, u1_addr}, 32'h123);
      checkOutput("ww_data", {16'd0, u1_data}, 32'hBEEF);
      checkOutput("ww_wait_dtack", {31'd0, u1_dtack}, 32'd1);
      tick();
      checkOutput("ww_access_we", {30'd0, u1_we_u, u1_we_l}, 32'd0);
      checkOutput("ww_access_dtack", {31'd0, u1_dtack}, 32'd1);
      tick();
      checkOutput("ww_ack_we", {30'd0, u1_we_u, u1_we_l}, 32'd3);
      checkOutput("ww_ack_dtack", {31'd0, u1_dtack}, 32'd0);
      tick();
      checkOutput("ww_ack_hold_dtack", {31'd0, u1_dtack}, 32'd0);
      as_n = 1'b1;
      tick();
      checkOutput("ww_release_dtack", {31'd0, u1_dtack}, 32'd1);

      // Byte write on the lower lane only.
      $display("[TB] byte write");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h045, 16'h1234);
      tick();
      checkOutput("bw_wait_we", {30'd0, u1_we_u, u1_we_l}, 32'd3);
      tick();
      checkOutput("bw_access_we", {30'd0, u1_we_u, u1_we_l}, 32'd2);
      tick();
      checkOutput("bw_ack_we", {30'd0, u1_we_u, u1_we_l}, 32'd3);
      checkOutput("bw_ack_dtack", {31'd0, u1_dtack}, 32'd0);
      checkOutput("bw_data", {16'd0, u1_data}, 32'h1234);
      checkOutput("bw_dout_kept", {16'd0, u1_dout}, 32'h0);
      as_n = 1'b1;
      tick();

      // Read through zero wait states with the RAM held for three clocks.
      $display("[TB] held read");
      ram_q    = 16'hCAFE;
      ram_hold = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'h200, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("rd_hold%0d_we", i), {30'd0, u0_we_u, u0_we_l}, 32'd3);
         checkOutput($sformatf("rd_hold%0d_dtack", i), {31'd0, u0_dtack}, 32'd1);
      end
      ram_hold = 1'b0;
      tick();
      checkOutput("rd_dout", {16'd0, u0_dout}, 32'hCAFE);
      checkOutput("rd_dtack", {31'd0, u0_dtack}, 32'd0);
      as_n = 1'b1;
      tick();
      tick();
      checkOutput("rd_release_dtack", {31'd0, u0_dtack}, 32'd1);

      // Abort during wait states.
      $display("[TB] abort");
      ram_q = 16'h0000;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'h3FF, 16'hAAAA);
      mon4 = 1'b1;
      tick();
      tick();
      as_n = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      mon4 = 1'b0;
      checkOutput("abort_no_activity", {31'd0, seen4}, 32'd0);
      checkOutput("abort_dtack", {31'd0, u4_dtack}, 32'd1);

      // Asynchronous reset while a write sits held in ACCESS.
      $display("[TB] reset during held write");
      ram_hold = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'h0AA, 16'h5555);
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("rst_dtack", {31'd0, u1_dtack}, 32'd1);
      checkOutput("rst_we", {30'd0, u1_we_u, u1_we_l}, 32'd3);
      checkOutput("rst_dout", {16'd0, u1_dout}, 32'h0);
      checkOutput("rst_addr", {22'd0, u1_addr}, 32'h0);
      as_n     = 1'b1;
      ram_hold = 1'b0;
      #2;
      reset_n = 1'b1;
      mon5 = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      mon5 = 1'b0;
      checkOutput("rst_no_strobe_after", {31'd0, seen5}, 32'd0);

      // Back-to-back writes with one idle clock between them.
      $display("[TB] back-to-back");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'h010, 16'h1111);
      mon6 = 1'b1;
      tick();
      tick();
      tick();
      as_n = 1'b1;
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'h020, 16'h2222);
      tick();
      checkOutput("b2b_addr2", {22'd0, u1_addr}, 32'h020);
      checkOutput("b2b_data2", {16'd0, u1_data}, 32'h2222);
      tick();
      tick();
      as_n = 1'b1;
      tick();
      tick();
      mon6 = 1'b0;
      #1;
      checkOutput("b2b_pulses_u", pulses_u6, 32'd2);
      checkOutput("b2b_pulses_l", pulses_l6, 32'd2);
      checkOutput("b2b_acks", acks6, 32'd2);
      checkOutput("b2b_final_dtack", {31'd0, u1_dtack}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/m68k_ram_bridge.md
Name: m68k_ram_bridge

Overview:
- Sits directly upstream of the byte-laned 16-bit unregistered work RAM.
- Turns raw 68000 bus cycles (AS_n, UDS_n, LDS_n, R/W, address decode) into latched RAM address/data, single-clock byte-lane write strobes and a DTACK_n handshake, with a programmable number of wait states.
- A hold input lets a higher-priority agent, such as the save-state bus, own the RAM. While hold is high the bridge stalls and does not corrupt RAM.

Parameters:
- WIDTHAD, 10, RAM word-address width; must match the downstream RAM.
- WAIT_STATES, 1, number of clocks inserted between request sample and RAM access; legal range 0..15.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cs  in  1  address-decode select for this RAM region
- as_n  in  1  68k address strobe
- uds_n  in  1  68k upper data strobe
- lds_n  in  1  68k lower data strobe
- rw  in  1  68k read/write (1 = read)
- addr  in  WIDTHAD  68k word address (A[WIDTHAD:1])
- din  in  16  68k write data
- dout  out  16  registered read data to 68k
- dtack_n  out  1  registered data acknowledge, active low
- ram_hold  in  1  1 = RAM owned by another agent; bridge must not access it
- ram_address  out  WIDTHAD  latched address to RAM
- ram_data  out  16  latched write data to RAM
- ram_we_uds_n  out  1  upper-byte write enable, active low
- ram_we_lds_n  out  1  lower-byte write enable, active low
- ram_q  in  16  combinational RAM read data for ram_address

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE, dtack_n=1, dout=0, ram_address=0, ram_data=0.
  - ram_we_uds_n = ram_we_lds_n = 1, wait counter = 0.
  - Takes effect immediately, including mid-cycle; no strobe is issued on the first clock after release.
- States: IDLE, WAIT, ACCESS, ACK.
- IDLE:
  - Request is valid when cs=1, as_n=0 and (uds_n=0 or lds_n=0).
  - On the edge sampling a valid request, latch addr→ram_address, din→ram_data, rw, ~uds_n, ~lds_n. Load counter = WAIT_STATES-1.
  - Go to WAIT if WAIT_STATES>0, else go to ACCESS.
- WAIT:
  - Counter decrements each clock; at 0, go to ACCESS.
  - If as_n=1 is sampled, go to IDLE; no RAM write occurs.
- ACCESS:
  - If ram_hold=1, remain in ACCESS, no strobes; the as_n abort rule still applies.
  - If ram_hold=0 and the cycle is a write: ram_we_uds_n / ram_we_lds_n are low in this clock for the latched lanes only. This is a combinational decode of state, latched lanes and ~ram_hold, held for exactly one clock. Go to ACK.
  - If ram_hold=0 and the cycle is a read: capture ram_q into dout on the leaving edge. Go to ACK.
- ACK:
  - dtack_n=0 (registered, low from the edge entering ACK).
  - Stay in ACK until as_n=1 is sampled, then dtack_n=1 on that edge and go to IDLE.
  - A new request is accepted no earlier than the following edge.
- Latency with hold=0:
  - Request sampled at edge 0; ACCESS occupies the cycle after edge WAIT_STATES.
  - dtack_n goes low at edge WAIT_STATES+1.
  - ram_hold adds one clock per held ACCESS cycle.
- Write data:
  - ram_data and ram_address stay stable from the latch edge until the next accepted request.
  - dout holds its last read value across writes.
- Outputs during IDLE/WAIT/ACK: strobes are always high; no RAM write is possible outside ACCESS.
- Strobes in the same edge as AS:
  - Strobes are sampled together with as_n; a request with both strobes high is ignored until a strobe falls.
  - Strobe changes after latching are ignored.
- cs falling mid-cycle has no effect once latched; only as_n ends a cycle.
- ram_hold rising in WAIT has no effect until ACCESS.
- The counter is 4 bits wide; WAIT_STATES values above 15 are illegal.

Test Plan:
- Word write, WAIT_STATES=1: addr=0x123, din=0xBEEF, uds_n=lds_n=0, rw=0 → both we strobes low for exactly 1 clock at cycle 2, ram_address=0x123, ram_data=0xBEEF, dtack_n low at edge 2, high at the edge after as_n=1.
- Byte write, lower lane only: lds_n=0, uds_n=1, din=0x1234 → only ram_we_lds_n pulses; ram_we_uds_n stays 1 throughout.
- Read with hold, WAIT_STATES=0: ram_q=0xCAFE, ram_hold=1 for 3 clocks during ACCESS → no strobes, dtack_n stays 1; dout=0xCAFE and dtack_n=0 one edge after hold drops.
- Abort: WAIT_STATES=4, as_n deasserted after 2 clocks → back to IDLE, no write strobe, dtack_n never asserted.
- Reset mid-ACCESS: reset_n=0 asynchronously during a held write → dtack_n=1, strobes=1, dout=0 immediately; after release no strobe occurs until a new request.
- Back-to-back: two consecutive writes with as_n high for 1 clock between → two separate single-clock strobe pulses, two dtack_n assertions, second ram_address/ram_data latched correctly.
